mult_seq_ctrl: RTL and testbench
================================

Name: mult_seq_ctrl

Overview:
- Sequential 8x8 unsigned shift-add multiplier controller.
- Time-shares one existing 16-bit carry-lookahead adder (CLA_16) across 8 iterations; the adder is the only arithmetic resource.
- Low-area alternative to the parallel array multiplier, for non-throughput-critical products.
- Owns the FSM, operand shift registers, accumulator, iteration counter and the start/busy/done handshake.

Parameters:
- SKIP_ZERO, 0: when 1, RUN exits early once the remaining multiplier bits are all zero. When 0, latency is fixed.

Ports:
- clk  in  1  rising-edge clock, the single clock domain.
- rst  in  1  synchronous reset, active-high.
- start  in  1  request; sampled only in IDLE or DONE.
- a  in  8  multiplicand; captured on the accepted start edge.
- b  in  8  multiplier; captured on the accepted start edge.
- busy  out  1  high while state == RUN.
- done  out  1  high for exactly the one cycle spent in DONE.
- p  out  16  product register; valid from done onward and held until the next done.

Behaviour:
- Reset: state=IDLE, busy=0, done=0, p=0, acc=0, cnt=0, mcand_sh=0, mplr=0. rst overrides every other input at the same edge.
- Internal registers:
  - mcand_sh[15:0]: shifted multiplicand.
  - mplr[7:0]: remaining multiplier bits.
  - acc[15:0]: partial product.
  - cnt[2:0]: iteration counter.
- States: IDLE, RUN, DONE.
- IDLE/DONE with start=1 at edge E0:
  - mcand_sh<={8'h00,a}, mplr<=b, acc<=0, cnt<=0, go to RUN.
  - Operands are captured only at this edge; a and b are don't-care afterwards.
- IDLE with start=0: stay in IDLE.
- DONE with start=0: go to IDLE after one cycle.
- RUN, each edge:
  - acc <= mplr[0] ? adder.s : acc.
  - mcand_sh <<= 1, mplr >>= 1, cnt <= cnt+1.
- Adder connection: x=acc, y=mcand_sh, Cin=0. The adder's GG/PP outputs are unused.
- No overflow is possible: the partial sum is always <= the final product <= 16'hFE01.
- RUN exit:
  - Leave RUN when cnt==7.
  - If SKIP_ZERO=1, also leave RUN when the post-shift mplr is zero, i.e. mplr[7:1]==0.
  - On exit: p <= next-acc value, go to DONE.
- Latency, SKIP_ZERO=0: start sampled at E0, done visible after E8, so 8 cycles.
  - busy is high between E0 and E8.
  - Back-to-back throughput is 1 product per 9 cycles.
- Latency, SKIP_ZERO=1: 1 + index of the highest set bit of b, with b=0 giving 1. Minimum 1 cycle, maximum 8.
- start while busy: ignored. There is no queueing and no error flag.
- start during DONE: accepted. done=1 that cycle, then busy=1 the next cycle, and p keeps the old result until the new done.
- rst mid-RUN: abort immediately to reset values, with p cleared. No done is issued for the aborted operation.
- All outputs are registered or decoded from the state register only; there is no combinational path from input to output.

Decomposition:
- Shared package mult_pkg:
  - State enum: IDLE=2'd0, RUN=2'd1, DONE=2'd2; 2'd3 is illegal and recovers to IDLE.
  - Constants OP_W=8, PROD_W=16, ITER_LAST=3'd7.
- Sub-modules: the single existing 16-bit CLA adder instance. No new sub-module is needed; FSM and datapath registers live in mult_seq_ctrl.

Test Plan:
- Reset then a=13, b=11, start pulse, SKIP_ZERO=0 -> busy=1 for 8 cycles, done after 8 cycles, p=16'h008F (143), done high exactly 1 cycle.
- a=255, b=255 -> p=16'hFE01. Then a=0, b=200 -> p=16'h0000. Then a=200, b=0 -> p=0, still 8 cycles.
- start re-asserted at cycles 3 and 5 of an active RUN with different operands -> ignored; p equals the first product, and there is exactly one done.
- start held high continuously, a=3, b=5 then a=7, b=9 presented at each DONE -> p=15 then 63, with a done every 9 cycles.
- rst asserted at cycle 4 of RUN (a=100, b=100) -> next cycle busy=0, done=0, p=0, state IDLE. A subsequent a=100, b=100 gives p=16'h2710.
- SKIP_ZERO=1: b=1, a=5 -> done after 1 cycle, p=5. b=8'h80, a=2 -> done after 8 cycles, p=16'h0100. b=0 -> done after 1 cycle, p=0.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential shift-add multiplier.
package mult_pkg;

    localparam int unsigned OP_W      = 8;
    localparam int unsigned PROD_W    = 16;
    localparam logic [2:0]  ITER_LAST = 3'd7;

    // 2'd3 is unused; the controller recovers from it to IDLE.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/mult_seq_ctrl_if.sv
// Start/busy/done handshake plus operand and product buses of the multiplier.
interface mult_seq_ctrl_if;
    import mult_pkg::*;

    logic              start;
    logic [OP_W-1:0]   a;
    logic [OP_W-1:0]   b;
    logic              busy;
    logic              done;
    logic [PROD_W-1:0] p;

    modport master (output start, a, b, input busy, done, p);
    modport slave  (input start, a, b, output busy, done, p);

endinterface

// File: rtl/CLA_16.sv
// 16-bit carry-lookahead adder: four 4-bit groups joined by a second lookahead level.
module CLA_16 (
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic        cin,
    output logic [15:0] s,
    output logic        gg,
    output logic        pp
);
    logic [15:0] w_g;
    logic [15:0] w_p;
    logic [3:0]  w_grp_g;
    logic [3:0]  w_grp_p;
    logic [3:0]  w_grp_c;

    assign w_g = x & y;
    assign w_p = x ^ y;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_grp_p[i] = &w_p[4*i +: 4];
            w_grp_g[i] = w_g[4*i+3]
                       | (w_p[4*i+3] & w_g[4*i+2])
                       | (&w_p[4*i+2 +: 2] & w_g[4*i+1])
                       | (&w_p[4*i+1 +: 3] & w_g[4*i]);
        end
    end

    assign w_grp_c[0] = cin;
    assign w_grp_c[1] = w_grp_g[0] | (w_grp_p[0] & cin);
    assign w_grp_c[2] = w_grp_g[1] | (w_grp_p[1] & w_grp_g[0]) | (&w_grp_p[1:0] & cin);
    assign w_grp_c[3] = w_grp_g[2] | (w_grp_p[2] & w_grp_g[1])
                      | (&w_grp_p[2:1] & w_grp_g[0]) | (&w_grp_p[2:0] & cin);

    assign gg = w_grp_g[3] | (w_grp_p[3] & w_grp_g[2])
              | (&w_grp_p[3:2] & w_grp_g[1]) | (&w_grp_p[3:1] & w_grp_g[0]);
    assign pp = &w_grp_p;

    always_comb begin
        logic v_c;
        s = '0;
        for (int i = 0; i < 4; i++) begin
            v_c = w_grp_c[i];
            for (int j = 0; j < 4; j++) begin
                s[4*i+j] = w_p[4*i+j] ^ v_c;
                v_c      = w_g[4*i+j] | (w_p[4*i+j] & v_c);
            end
        end
    end

endmodule

// File: rtl/mult_seq_ctrl.sv
// Sequential 8x8 unsigned shift-add multiplier; one CLA_16 is reused on every iteration.
module mult_seq_ctrl
    import mult_pkg::*;
#(
    parameter bit SKIP_ZERO = 1'b0
) (
    input  logic           clk,
    input  logic           rst,
    mult_seq_ctrl_if.slave bus
);
    state_e            r_state;
    state_e            w_state_d;
    logic [PROD_W-1:0] r_mcand_sh;
    logic [PROD_W-1:0] r_acc;
    logic [PROD_W-1:0] r_p;
    logic [OP_W-1:0]   r_mplr;
    logic [2:0]        r_cnt;
    logic [PROD_W-1:0] w_sum;
    logic [PROD_W-1:0] w_acc_d;
    logic              w_last;
    logic              w_gg;
    logic              w_pp;
    logic              w_unused_gp;

    CLA_16 u_cla (
        .x   (r_acc),
        .y   (r_mcand_sh),
        .cin (1'b0),
        .s   (w_sum),
        .gg  (w_gg),
        .pp  (w_pp)
    );

    assign w_unused_gp = w_gg ^ w_pp;

    assign w_acc_d = r_mplr[0] ? w_sum : r_acc;
    // Early exit looks at the multiplier bits that remain after this iteration's shift.
    assign w_last  = (r_cnt == ITER_LAST) || (SKIP_ZERO && (r_mplr[OP_W-1:1] == '0));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_state_d = RUN;
            RUN:     if (w_last) w_state_d = DONE;
            DONE:    w_state_d = bus.start ? RUN : IDLE;
            default: w_state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcand_sh <= '0;
            r_mplr     <= '0;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_p        <= '0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        r_mcand_sh <= {{(PROD_W-OP_W){1'b0}}, bus.a};
                        r_mplr     <= bus.b;
                        r_acc      <= '0;
                        r_cnt      <= '0;
                    end
                end
                RUN: begin
                    r_acc      <= w_acc_d;
                    r_mcand_sh <= r_mcand_sh << 1;
                    r_mplr     <= r_mplr >> 1;
                    r_cnt      <= r_cnt + 3'd1;
                    if (w_last) r_p <= w_acc_d;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = (r_state == RUN);
    assign bus.done = (r_state == DONE);
    assign bus.p    = r_p;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Self-checking bench: runs a fixed-latency and a skip-zero instance side by side.
module tb_mult_seq_ctrl;
    import mult_pkg::*;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        int         p;
        int         lat0;
        int         lat1;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       tb_start;
    logic [7:0] tb_a;
    logic [7:0] tb_b;
    int         n_vec = 0;
    int         n_bad = 0;

    mult_seq_ctrl_if if0 ();
    mult_seq_ctrl_if if1 ();

    assign if0.start = tb_start;
    assign if0.a     = tb_a;
    assign if0.b     = tb_b;
    assign if1.start = tb_start;
    assign if1.a     = tb_a;
    assign if1.b     = tb_b;

    mult_seq_ctrl #(.SKIP_ZERO(1'b0)) u_dut0 (.clk(clk), .rst(rst), .bus(if0));
    mult_seq_ctrl #(.SKIP_ZERO(1'b1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Skip-zero latency model: one cycle per multiplier bit up to the highest set bit.
    function automatic int ref_lat_skip(input logic [7:0] vb);
        int l = 1;
        for (int i = 0; i < 8; i++) if (vb[i]) l = i + 1;
        return l;
    endfunction

    task automatic run_op(input logic [7:0] va, input logic [7:0] vb, input int exp_p,
                          input int exp_lat0, input int exp_lat1);
        int lat0 = -1, lat1 = -1, nb0 = 0, nb1 = 0, nd0 = 0, nd1 = 0, p0 = -1, p1 = -1;
        tb_a = va;
        tb_b = vb;
        tb_start = 1'b1;
        tick();
        tb_start = 1'b0;
        tb_a = 8'($urandom);
        tb_b = 8'($urandom);
        for (int k = 0; k < 12; k++) begin
            if (if0.busy) nb0++;
            if (if1.busy) nb1++;
            if (if0.done) begin nd0++; lat0 = k; p0 = int'(if0.p); end
            if (if1.done) begin nd1++; lat1 = k; p1 = int'(if1.p); end
            tick();
        end
        check($sformatf("p0 %0d*%0d", va, vb), p0, exp_p);
        check($sformatf("p1 %0d*%0d", va, vb), p1, exp_p);
        check($sformatf("lat0 %0d*%0d", va, vb), lat0, exp_lat0);
        check($sformatf("lat1 %0d*%0d", va, vb), lat1, exp_lat1);
        check($sformatf("busy0 %0d*%0d", va, vb), nb0, exp_lat0);
        check($sformatf("busy1 %0d*%0d", va, vb), nb1, exp_lat1);
        check($sformatf("ndone0 %0d*%0d", va, vb), nd0, 1);
        check($sformatf("ndone1 %0d*%0d", va, vb), nd1, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl [7];
        int nd0, nd1, p0, p1, first, second;

        tbl[0] = '{8'd13,  8'd11,  143,   8, 4};
        tbl[1] = '{8'd255, 8'd255, 65025, 8, 8};
        tbl[2] = '{8'd0,   8'd200, 0,     8, 8};
        tbl[3] = '{8'd200, 8'd0,   0,     8, 1};
        tbl[4] = '{8'd5,   8'd1,   5,     8, 1};
        tbl[5] = '{8'd2,   8'h80,  256,   8, 8};
        tbl[6] = '{8'd100, 8'd100, 10000, 8, 7};

        rst = 1'b1;
        tb_start = 1'b1;
        tb_a = 8'd9;
        tb_b = 8'd9;
        tick();
        tick();
        check("reset busy0", int'(if0.busy), 0);
        check("reset done0", int'(if0.done), 0);
        check("reset p0", int'(if0.p), 0);
        check("reset busy1", int'(if1.busy), 0);
        check("reset done1", int'(if1.done), 0);
        check("reset p1", int'(if1.p), 0);
        tb_start = 1'b0;
        rst = 1'b0;
        tick();

        foreach (tbl[i]) run_op(tbl[i].a, tbl[i].b, tbl[i].p, tbl[i].lat0, tbl[i].lat1);

        // start pulses at run cycles 3 and 5 must be ignored
        tb_a = 8'd50;
        tb_b = 8'd200;
        tb_start = 1'b1;
        tick();
        tb_start = 1'b0;
        nd0 = 0; nd1 = 0; p0 = -1; p1 = -1;
        for (int k = 0; k < 12; k++) begin
            if (if0.done) begin nd0++; p0 = int'(if0.p); end
            if (if1.done) begin nd1++; p1 = int'(if1.p); end
            tb_start = (k == 2 || k == 4);
            tb_a = 8'd1;
            tb_b = 8'd1;
            tick();
        end
        tb_start = 1'b0;
        check("ignore ndone0", nd0, 1);
        check("ignore ndone1", nd1, 1);
        check("ignore p0", p0, 10000);
        check("ignore p1", p1, 10000);

        // reset mid-run aborts and clears p
        tb_a = 8'd100;
        tb_b = 8'd100;
        tb_start = 1'b1;
        tick();
        tb_start = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort busy0", int'(if0.busy), 0);
        check("abort done0", int'(if0.done), 0);
        check("abort p0", int'(if0.p), 0);
        check("abort busy1", int'(if1.busy), 0);
        check("abort done1", int'(if1.done), 0);
        check("abort p1", int'(if1.p), 0);
        nd0 = 0; nd1 = 0;
        for (int k = 0; k < 10; k++) begin
            if (if0.done) nd0++;
            if (if1.done) nd1++;
            tick();
        end
        check("abort no done0", nd0, 0);
        check("abort no done1", nd1, 0);
        run_op(8'd100, 8'd100, 10000, 8, 7);

        // start held high; next operands presented during DONE (fixed-latency instance)
        tb_a = 8'd3;
        tb_b = 8'd5;
        tb_start = 1'b1;
        tick();
        first = -1;
        second = -1;
        for (int k = 0; k < 30 && second < 0; k++) begin
            if (first >= 0 && k == first + 1) begin
                check("cont busy after done", int'(if0.busy), 1);
                check("cont p held", int'(if0.p), 15);
            end
            if (if0.done) begin
                if (first < 0) begin
                    first = k;
                    check("cont p first", int'(if0.p), 15);
                    tb_a = 8'd7;
                    tb_b = 8'd9;
                end else begin
                    second = k;
                    check("cont p second", int'(if0.p), 63);
                end
            end
            tick();
        end
        tb_start = 1'b0;
        check("cont first done cycle", first, 8);
        check("cont done spacing", second - first, 9);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();

        for (int i = 0; i < 20; i++) begin
            logic [7:0] ra, rb;
            ra = 8'($urandom);
            rb = 8'($urandom);
            if (i == 0) rb = 8'd0;
            run_op(ra, rb, int'(ra) * int'(rb), 8, ref_lat_skip(rb));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
